// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: credit-limited request issue, in-order PC tag queue,
// DEPTH-entry instruction buffer and redirect flush of stale in-flight responses.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              pc_q, pc_d;
  logic [CW-1:0]            out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [PW-1:0]            tw_q, tw_d, tr_q, tr_d, fw_q, fw_d, fr_q, fr_d;
  logic [DEPTH-1:0][31:0]   tag_q, tag_d, inst_q, inst_d, ipc_q, ipc_d;
  logic [CW:0]              credits;
  logic                     grant, push, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign credits      = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_o   = (state_q == RUN) & ~rst & ~redirect_i & (credits < (CW+1)'(DEPTH));
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = (cnt_q != '0);
  assign inst_o       = inst_q[fr_q];
  assign inst_pc_o    = ipc_q[fr_q];

  assign grant = imem_req_o & imem_gnt_i;
  assign push  = imem_rvalid_i & (state_q == RUN) & ~redirect_i;
  assign pop   = inst_valid_o & inst_ready_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    disc_d  = disc_q;
    tw_d    = tw_q;
    tr_d    = tr_q;
    fw_d    = fw_q;
    fr_d    = fr_q;
    tag_d   = tag_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    out_d   = out_q + CW'(grant) - CW'(imem_rvalid_i);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);

    // Tag queue tracks every granted fetch, including ones later discarded.
    if (grant) begin
      tag_d[tw_q] = pc_q;
      tw_d        = inc(tw_q);
      pc_d        = pc_q + 32'd4;
    end
    if (imem_rvalid_i) tr_d = inc(tr_q);

    if (push) begin
      inst_d[fw_q] = imem_rdata_i;
      ipc_d[fw_q]  = tag_q[tr_q];
      fw_d         = inc(fw_q);
    end
    if (pop) fr_d = inc(fr_q);

    if (redirect_i) begin
      pc_d    = {redirect_pc_i[31:2], 2'b00};
      fw_d    = '0;
      fr_d    = '0;
      cnt_d   = '0;
      disc_d  = out_q - CW'(imem_rvalid_i);
      state_d = (disc_d != '0) ? FLUSH : RUN;
    end else if (state_q == FLUSH && imem_rvalid_i) begin
      disc_d = disc_q - CW'(1);
      if (disc_q == CW'(1)) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
      tw_q    <= '0;
      tr_q    <= '0;
      fw_q    <= '0;
      fr_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      tw_q    <= tw_d;
      tr_q    <= tr_d;
      fw_q    <= fw_d;
      fr_q    <= fr_d;
    end
    tag_q  <= tag_d;
    inst_q <= inst_d;
    ipc_q  <= ipc_d;
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a 1-cycle memory model with a hold switch, and a
// scoreboard of expected {pc, instruction} pairs popped as decode consumes them.
module tb_fetch_ctrl;
  localparam int          DEPTH = 3;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, redirect_i, imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i, inst_o, inst_pc_o;

  int          checks = 0, errors = 0, cyc = 0, grants = 0, gnt_left = 0;
  int          first_pop = -1, last_pop = -1;
  bit          hold = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];

  fetch_ctrl #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_rv();
    imem_rvalid_i = !hold && !rst && pend.size() > 0;
    imem_rdata_i  = 32'h0;
    if (imem_rvalid_i) imem_rdata_i = mdata(pend[0]);
  endtask

  task automatic tick();
    logic g, rv, pop;
    logic [31:0] a, pc, ins, e;
    imem_gnt_i = (gnt_left > 0);
    g   = imem_req_o & imem_gnt_i;
    a   = imem_addr_o;
    rv  = imem_rvalid_i;
    pop = inst_valid_o & inst_ready_i;
    pc  = inst_pc_o;
    ins = inst_o;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) pend.delete();
    else begin
      if (rv) void'(pend.pop_front());
      if (g) begin
        pend.push_back(a);
        grants++;
        gnt_left--;
      end
    end
    if (pop) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pop: observed pc %h expected none", pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("inst_pc", pc, e);
        chk("inst", ins, mdata(e));
      end
    end
    set_rv();
  endtask

  task automatic drain(input int bound);
    int t = 0;
    while (exp_q.size() > 0 && t < bound) begin
      tick();
      t++;
    end
    chk("drain", exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic wait_grants(input int target);
    int t = 0;
    while (grants < target && t < 20) begin
      tick();
      t++;
    end
    chk("grant_wait", grants, target);
  endtask

  initial begin
    int g0;
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; inst_ready_i = 1'b1;
    tick(); tick();
    chkb("rst_req", imem_req_o, 1'b0);
    chkb("rst_valid", inst_valid_o, 1'b0);
    rst = 1'b0; #1;
    chkb("post_rst_req", imem_req_o, 1'b1);
    chk("post_rst_addr", imem_addr_o, RPC);

    // Streaming: one instruction per cycle once the pipe fills.
    first_pop = -1;
    for (int i = 0; i < 8; i++) exp_q.push_back(RPC + 32'(4 * i));
    gnt_left = 8;
    drain(40);
    chk("stream_rate", last_pop - first_pop, 7);
    chkb("idle_req", imem_req_o, 1'b1);
    chk("idle_addr", imem_addr_o, 32'd32);

    // Backpressure: credits run out after DEPTH grants, head stays put.
    inst_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'd32 + 32'(4 * i));
    gnt_left = 6; g0 = grants;
    repeat (10) tick();
    chk("bp_grants", grants - g0, DEPTH);
    chkb("bp_req", imem_req_o, 1'b0);
    chkb("bp_valid", inst_valid_o, 1'b1);
    chk("bp_pc", inst_pc_o, 32'd32);
    chk("bp_inst", inst_o, mdata(32'd32));
    inst_ready_i = 1'b1;
    drain(40);

    // Redirect with two fetches outstanding.
    hold = 1'b1; set_rv();
    gnt_left = 2;
    wait_grants(grants + 2);
    redirect_pc_i = 32'h0000_1003; redirect_i = 1'b1;
    tick();
    redirect_i = 1'b0; #1;
    chkb("rd_flush_req", imem_req_o, 1'b0);
    chk("rd_addr", imem_addr_o, 32'h0000_1000);
    chkb("rd_valid", inst_valid_o, 1'b0);
    hold = 1'b0; set_rv();
    exp_q.push_back(32'h0000_1000); exp_q.push_back(32'h0000_1004);
    gnt_left = 2;
    tick();
    chkb("flush_valid0", inst_valid_o, 1'b0);
    chkb("flush_req0", imem_req_o, 1'b0);
    tick();
    chkb("flush_valid1", inst_valid_o, 1'b0);
    chkb("resume_req", imem_req_o, 1'b1);
    chk("resume_addr", imem_addr_o, 32'h0000_1000);
    drain(40);

    // Redirect coinciding with a response and a pop.
    exp_q.push_back(32'h0000_1008); exp_q.push_back(32'h0000_100C);
    gnt_left = 3;
    tick(); tick(); tick();
    chkb("coinc_rv", imem_rvalid_i, 1'b1);
    chkb("coinc_valid", inst_valid_o, 1'b1);
    redirect_pc_i = 32'h0000_2000; redirect_i = 1'b1;
    tick();
    redirect_i = 1'b0; #1;
    chkb("coinc_empty", inst_valid_o, 1'b0);
    chkb("coinc_req", imem_req_o, 1'b1);
    chk("coinc_addr", imem_addr_o, 32'h0000_2000);
    exp_q.push_back(32'h0000_2000); exp_q.push_back(32'h0000_2004);
    gnt_left = 2;
    drain(40);

    // PC wrap at the top of the address space.
    redirect_pc_i = 32'hFFFF_FFF8; redirect_i = 1'b1;
    tick();
    redirect_i = 1'b0; #1;
    chk("wrap_start", imem_addr_o, 32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    gnt_left = 3;
    drain(40);
    chk("wrap_addr", imem_addr_o, 32'h0000_0004);

    // Reset while flushing.
    hold = 1'b1; set_rv();
    gnt_left = 2;
    wait_grants(grants + 2);
    redirect_pc_i = 32'h0000_3000; redirect_i = 1'b1;
    tick();
    redirect_i = 1'b0; #1;
    chkb("rf_flush_req", imem_req_o, 1'b0);
    tick();
    rst = 1'b1; #1;
    chkb("rf_rst_req_comb", imem_req_o, 1'b0);
    tick();
    chkb("rf_rst_req", imem_req_o, 1'b0);
    chkb("rf_rst_valid", inst_valid_o, 1'b0);
    tick();
    rst = 1'b0; hold = 1'b0; set_rv(); #1;
    chkb("rf_req", imem_req_o, 1'b1);
    chk("rf_addr", imem_addr_o, RPC);
    chkb("rf_valid", inst_valid_o, 1'b0);
    exp_q.push_back(RPC); exp_q.push_back(RPC + 32'd4);
    gnt_left = 2;
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
